router_egress_scheduler: RTL and testbench

Drains the router's three output channels (data_out_N / vld_out_N / re_N) onto one shared 8-bit egress link with valid/ready handshake. Arbitrates packet-by-packet with round-robin fairness: a granted channel is held from header through parity byte. Reads are issued early enough that the router's per-channel read timeout is never the limiting factor. Sits directly downstream of the router top, one instance per router.

---
 rtl/router_egress_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_router_egress_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_egress_scheduler.sv
// Purpose: round-robin, packet-granular drain of three router channels onto one byte-wide valid/ready egress link.
// Latency: one arbitration cycle, header read to link_valid in two cycles, then 1 byte/cycle with link_ready high.
// Backpressure: link_ready stalls a 2-entry output buffer; a read is issued only when a buffer slot is guaranteed.
module router_egress_scheduler #(
   parameter int DATA_W    = 8,
   parameter int STALL_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_out_0,
   input  logic              vld_out_1,
   input  logic              vld_out_2,
   input  logic [DATA_W-1:0] data_out_0,
   input  logic [DATA_W-1:0] data_out_1,
   input  logic [DATA_W-1:0] data_out_2,
   output logic              re_0,
   output logic              re_1,
   output logic              re_2,
   output logic [DATA_W-1:0] link_data,
   output logic              link_valid,
   input  logic              link_ready,
   output logic              link_sop,
   output logic              link_eop,
   output logic              link_err,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int SW = $clog2(STALL_MAX + 1);

   typedef enum logic [2:0] {IDLE, RD_HDR, RD_BODY, FLUSH, ABORT} state_t;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] dat;
   } entry_t;

   state_t            state, state_nxt;
   logic [1:0]        gnt_q, last_q, arb_ch;
   logic [1:0]        p0, p1, p2;
   logic              arb_vld;
   logic [2:0]        vld_vec;
   logic              vld_g;
   logic [DATA_W-1:0] dat_g;

   entry_t            obuf_mem [2];
   logic              ob_rd, ob_wr;
   logic [1:0]        occ;
   logic              push, pop;

   logic              infl, infl_sop, infl_eop;
   logic [6:0]        remaining, rem_eff;
   logic [SW-1:0]     stall_cnt;
   logic              stall_hit, credit;
   logic              issue, iss_sop, iss_eop;
   logic [2:0]        used;
   entry_t            head;

   assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};

   // Mux the granted channel's status and read data.
   always_comb begin
      vld_g = 1'b0;
      dat_g = '0;
      case (gnt_q)
         2'd0:    begin vld_g = vld_out_0; dat_g = data_out_0; end
         2'd1:    begin vld_g = vld_out_1; dat_g = data_out_1; end
         2'd2:    begin vld_g = vld_out_2; dat_g = data_out_2; end
         default: ;
      endcase
   end

   // Round-robin pick: search last+1, last+2, last.
   always_comb begin
      case (last_q)
         2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      arb_vld = |vld_vec;
      arb_ch  = p2;
      if (vld_vec[p0])      arb_ch = p0;
      else if (vld_vec[p1]) arb_ch = p1;
   end

   // The header sits on data_out the cycle after its read, so the body count is
   // taken straight from it; this lets the first body read overlap the header capture.
   assign pop       = (occ != 2'd0) && link_ready;
   assign push      = infl;
   assign used      = {1'b0, occ} + {2'b00, infl};
   assign credit    = pop ? (used < 3'd3) : (used < 3'd2);
   assign rem_eff   = (infl && infl_sop) ? ({1'b0, dat_g[7:2]} + 7'd1) : remaining;
   assign stall_hit = !vld_g && (stall_cnt == SW'(STALL_MAX - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, read issue and abort pulse.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      iss_sop   = 1'b0;
      iss_eop   = 1'b0;
      link_err  = 1'b0;
      case (state)
         IDLE: begin
            if (arb_vld) state_nxt = RD_HDR;
         end
         RD_HDR: begin
            if (stall_hit) begin
               state_nxt = ABORT;
            end else if (vld_g && credit) begin
               issue     = 1'b1;
               iss_sop   = 1'b1;
               state_nxt = RD_BODY;
            end
         end
         RD_BODY: begin
            if (stall_hit) begin
               state_nxt = ABORT;
            end else if (vld_g && credit && (rem_eff != 7'd0)) begin
               issue   = 1'b1;
               iss_eop = (rem_eff == 7'd1);
               if (rem_eff == 7'd1) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            // Leave as soon as the eop byte is accepted.
            if (!infl && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = IDLE;
         end
         ABORT: begin
            if (!infl && (occ == 2'd0)) begin
               link_err  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant capture at arbitration; remember the served channel on return to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q  <= 2'd0;
         last_q <= 2'd2;
      end else begin
         if (state == IDLE && arb_vld) gnt_q <= arb_ch;
         if (state != IDLE && state_nxt == IDLE) last_q <= gnt_q;
      end
   end

   // Bytes still to be read for the packet, and the consecutive-stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         stall_cnt <= '0;
      end else begin
         if (state == RD_BODY) remaining <= rem_eff - {6'd0, issue};
         else                  remaining <= '0;
         if ((state == RD_HDR || state == RD_BODY) && !vld_g) stall_cnt <= stall_cnt + SW'(1);
         else                                                 stall_cnt <= '0;
      end
   end

   // One read may be in flight; its tags travel with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl     <= 1'b0;
         infl_sop <= 1'b0;
         infl_eop <= 1'b0;
      end else begin
         infl     <= issue;
         infl_sop <= iss_sop;
         infl_eop <= iss_eop;
      end
   end

   // Two-entry output buffer; simultaneous push and pop keep occupancy and order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obuf_mem[0] <= '0;
         obuf_mem[1] <= '0;
         ob_rd       <= 1'b0;
         ob_wr       <= 1'b0;
         occ         <= 2'd0;
      end else begin
         if (push) begin
            obuf_mem[ob_wr] <= {infl_sop, infl_eop, dat_g};
            ob_wr           <= ~ob_wr;
         end
         if (pop) ob_rd <= ~ob_rd;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head       = obuf_mem[ob_rd];
   assign link_valid = (occ != 2'd0);
   assign link_data  = link_valid ? head.dat : '0;
   assign link_sop   = link_valid & head.sop;
   assign link_eop   = link_valid & head.eop;
   assign re_0       = issue && (gnt_q == 2'd0);
   assign re_1       = issue && (gnt_q == 2'd1);
   assign re_2       = issue && (gnt_q == 2'd2);
   assign busy       = (state != IDLE);
   assign grant      = (state == IDLE) ? 2'd0 : gnt_q;

endmodule

// File: tb/tb_router_egress_scheduler.sv
// Bench for router_egress_scheduler: router FIFO models feed packets, a packet-level
// round-robin model predicts the egress byte stream, per-cycle rules check reads and link.
// Table rows cover single packets; hand-written sequences cover order, abort and reset.
module tb_router_egress_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
   logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
   logic       re_0, re_1, re_2;
   logic [7:0] link_data;
   logic       link_valid, link_sop, link_eop, link_err, busy;
   logic       link_ready = 1'b0;
   logic [1:0] grant;

   router_egress_scheduler #(.DATA_W(8), .STALL_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
      .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
      .re_0(re_0), .re_1(re_1), .re_2(re_2),
      .link_data(link_data), .link_valid(link_valid), .link_ready(link_ready),
      .link_sop(link_sop), .link_eop(link_eop), .link_err(link_err),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] dat; logic sop; logic eop; logic [1:0] ch; } exp_t;
   typedef struct { int ch; int len; int addr; int base; int par; int rdy; int exp_bytes; } vec_t;

   int         vectors = 0, miscompares = 0;
   exp_t       exp_q[$];
   logic [7:0] chq[3][$];
   logic [7:0] mir[3][$];
   int         pend[3][$];
   int         mdl_last = 2;
   logic       frc[3];
   int         rdy_pct = 100;
   int         cyc = 0, rd_cnt = 0, hs_cnt = 0;
   int         re_cnt[3];
   int         first_hs = -1, last_hs = -1, eop_cyc = -1, busy_fall = -1, err_cnt = 0, err_cyc = -1;
   logic       prev_stall = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0, prev_busy = 1'b0;
   logic [7:0] prev_dat = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic load_pkt(input int ch, input int len, input int addr, input int base,
                           input logic [7:0] par, input bit rnd);
      logic [7:0] b;
      b = {6'(len), 2'(addr)};
      chq[ch].push_back(b); mir[ch].push_back(b);
      for (int i = 0; i < len; i++) begin
         b = rnd ? 8'($urandom) : 8'(base + i);
         chq[ch].push_back(b); mir[ch].push_back(b);
      end
      chq[ch].push_back(par); mir[ch].push_back(par);
      pend[ch].push_back(len + 2);
   endtask

   // Packet-level round robin over whatever the channels hold.
   task automatic plan();
      int c, n, cc;
      bit found;
      exp_t e;
      while (pend[0].size() + pend[1].size() + pend[2].size() > 0) begin
         found = 0; c = 0;
         for (int k = 1; k <= 3; k++) begin
            cc = (mdl_last + k) % 3;
            if (!found && pend[cc].size() > 0) begin found = 1; c = cc; end
         end
         n = pend[c].pop_front();
         for (int i = 0; i < n; i++) begin
            e.dat = mir[c].pop_front(); e.sop = (i == 0); e.eop = (i == n - 1); e.ch = 2'(c);
            exp_q.push_back(e);
         end
         mdl_last = c;
      end
   endtask

   task automatic clear_all();
      for (int k = 0; k < 3; k++) begin
         chq[k].delete(); mir[k].delete(); pend[k].delete(); frc[k] = 1'b0; re_cnt[k] = 0;
      end
      exp_q.delete();
      mdl_last = 2; rd_cnt = 0; hs_cnt = 0; prev_stall = 1'b0; prev_busy = 1'b0;
      vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
      data_out_0 = '0; data_out_1 = '0; data_out_2 = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; link_ready = 1'b0;
      clear_all();
      @(negedge clk);
      #1;
      check("reset_outputs", {re_2, re_1, re_0, link_valid, link_sop, link_eop, link_err, busy, grant, link_data}, 0);
      rst = 1'b0;
   endtask

   task automatic cycle();
      logic [2:0] re_s;
      logic       hs;
      exp_t       e;
      @(negedge clk);
      vld_out_0 = (chq[0].size() != 0) && !frc[0];
      vld_out_1 = (chq[1].size() != 0) && !frc[1];
      vld_out_2 = (chq[2].size() != 0) && !frc[2];
      link_ready = ($urandom_range(99) < rdy_pct);
      #1;
      re_s = {re_2, re_1, re_0};
      hs   = link_valid && link_ready;
      vectors++;
      if ((re_s != 3'b000) && (!busy || re_s != (3'b001 << grant) ||
          (re_s & {vld_out_2, vld_out_1, vld_out_0}) != re_s)) begin
         miscompares++;
         $display("FAIL re_rule: re=%b grant=%0d busy=%b vld=%b (cycle %0d)", re_s, grant, busy,
                  {vld_out_2, vld_out_1, vld_out_0}, cyc);
      end
      if (prev_stall) check("hold_while_stalled", {link_valid, link_sop, link_eop, link_data},
                            {1'b1, prev_sop, prev_eop, prev_dat});
      if (rd_cnt - hs_cnt > 2) check("outstanding_le2", rd_cnt - hs_cnt, 2);
      if (hs) begin
         hs_cnt++;
         if (exp_q.size() == 0) check("unexpected_byte", {link_sop, link_eop, link_data}, 0);
         else begin
            e = exp_q.pop_front();
            check("link_byte{grant,sop,eop,data}", {grant, link_sop, link_eop, link_data},
                  {e.ch, e.sop, e.eop, e.dat});
         end
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         if (link_eop) eop_cyc = cyc;
      end
      if (link_err) begin err_cnt++; err_cyc = cyc; end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy; prev_stall = link_valid && !link_ready;
      prev_dat = link_data; prev_sop = link_sop; prev_eop = link_eop;
      @(posedge clk);
      #1;
      cyc++;
      if (re_s[0]) begin re_cnt[0]++; rd_cnt++; data_out_0 = chq[0].pop_front(); end
      if (re_s[1]) begin re_cnt[1]++; rd_cnt++; data_out_1 = chq[1].pop_front(); end
      if (re_s[2]) begin re_cnt[2]++; rd_cnt++; data_out_2 = chq[2].pop_front(); end
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !prev_busy && chq[0].size() == 0 && chq[1].size() == 0 &&
               chq[2].size() == 0 && n > 1) && n < budget) begin
         cycle();
         n++;
      end
      if (n >= budget) check("drain_timeout_pending_bytes", exp_q.size(), 0);
   endtask

   vec_t tbl[5];

   initial begin
      int h0, fstart, n, tot;
      bit found;
      tbl[0] = '{1,  3, 1, 'hA1, 'h5C, 100,  5};
      tbl[1] = '{0,  0, 0, 'h00, 'h00, 100,  2};
      tbl[2] = '{2, 10, 2, 'h30, 'h77,  50, 12};
      tbl[3] = '{0, 63, 3, 'h80, 'h3C, 100, 65};
      tbl[4] = '{2,  1, 0, 'hE0, 'h11,  25,  3};

      do_reset();

      // Single-packet table.
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 3; k++) re_cnt[k] = 0;
         first_hs = -1; last_hs = -1; eop_cyc = -1; busy_fall = -1;
         h0 = hs_cnt;
         rdy_pct = tbl[r].rdy;
         load_pkt(tbl[r].ch, tbl[r].len, tbl[r].addr, tbl[r].base, 8'(tbl[r].par), 1'b0);
         plan();
         run(600);
         check("re_count", re_cnt[tbl[r].ch], tbl[r].exp_bytes);
         check("bytes_delivered", hs_cnt - h0, tbl[r].exp_bytes);
         if (tbl[r].rdy == 100) check("contiguous_span", last_hs - first_hs + 1, tbl[r].exp_bytes);
         check("busy_drop_after_eop", ((busy_fall - eop_cyc) >= 1) && ((busy_fall - eop_cyc) <= 2), 1);
         check("grant_when_idle", grant, 0);
      end

      // Three preloaded 2-byte packets after reset, then ch0 and ch2 again.
      do_reset();
      rdy_pct = 100;
      load_pkt(0, 0, 0, 0, 8'h10, 1'b0);
      load_pkt(1, 0, 1, 0, 8'h21, 1'b0);
      load_pkt(2, 0, 2, 0, 8'h32, 1'b0);
      plan();
      run(200);
      load_pkt(2, 0, 2, 0, 8'h52, 1'b0);
      load_pkt(0, 0, 0, 0, 8'h40, 1'b0);
      plan();
      run(200);
      check("order_all_consumed", exp_q.size(), 0);

      // Random multi-packet traffic under random backpressure.
      rdy_pct = 50; err_cnt = 0; tot = 0;
      h0 = hs_cnt; n = rd_cnt;
      for (int p = 0; p < 12; p++) begin
         int len;
         len = $urandom_range(0, 20);
         tot += len + 2;
         load_pkt($urandom_range(0, 2), len, $urandom_range(0, 3), 0, 8'($urandom), 1'b1);
      end
      plan();
      run(4000);
      check("random_bytes", hs_cnt - h0, tot);
      check("random_reads", rd_cnt - n, tot);
      check("random_no_err", err_cnt, 0);

      // Stall abort: ch1 len 5 starves after three bytes.
      rdy_pct = 100; err_cnt = 0; err_cyc = -1;
      for (int k = 0; k < 3; k++) re_cnt[k] = 0;
      chq[1].push_back(8'h15);
      for (int i = 0; i < 5; i++) chq[1].push_back(8'(8'h61 + i));
      chq[1].push_back(8'h99);
      exp_q.push_back('{8'h15, 1'b1, 1'b0, 2'd1});
      exp_q.push_back('{8'h61, 1'b0, 1'b0, 2'd1});
      exp_q.push_back('{8'h62, 1'b0, 1'b0, 2'd1});
      n = 0;
      while (re_cnt[1] < 3 && n < 50) begin cycle(); n++; end
      check("abort_reads_before_stall", re_cnt[1], 3);
      frc[1] = 1'b1; fstart = cyc;
      n = 0;
      while (err_cnt == 0 && n < 60) begin cycle(); n++; end
      for (int i = 0; i < 4; i++) cycle();
      check("abort_err_pulses", err_cnt, 1);
      check("abort_err_timing", ((err_cyc - fstart) >= 16) && ((err_cyc - fstart) <= 18), 1);
      check("abort_no_more_reads", re_cnt[1], 3);
      check("abort_buffer_drained", exp_q.size(), 0);
      check("abort_back_to_idle", {busy, grant}, 0);
      frc[1] = 1'b0; chq[1].delete();
      mdl_last = 1;
      load_pkt(0, 2, 0, 8'hC0, 8'h01, 1'b0);
      load_pkt(2, 2, 2, 8'hD0, 8'h02, 1'b0);
      plan();
      run(200);

      // Asynchronous reset with two bytes parked in the buffer.
      do_reset();
      rdy_pct = 0;
      load_pkt(0, 10, 0, 8'h70, 8'h0F, 1'b0);
      n = 0; found = 0;
      while (!found && n < 40) begin
         cycle(); n++;
         if (link_valid && (rd_cnt == 2)) found = 1;
      end
      for (int i = 0; i < 3; i++) cycle();
      check("parked_bytes", {link_valid, rd_cnt - hs_cnt}, {1'b1, 32'd2});
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_clears", {link_valid, re_2, re_1, re_0, busy, grant}, 0);
      clear_all();
      @(negedge clk);
      rst = 1'b0;
      rdy_pct = 100;
      load_pkt(2, 1, 2, 8'hA0, 8'h55, 1'b0);
      load_pkt(1, 1, 1, 8'hB0, 8'h66, 1'b0);
      load_pkt(0, 1, 0, 8'hC0, 8'h77, 1'b0);
      plan();
      check("first_after_reset_is_ch0", exp_q[0].ch, 0);
      run(200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
